fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
Pointer and flag controller for the FIFO storage array, sitting directly upstream of the memory stage. Accepts push/pop requests from the producer and consumer, and qualifies them against full/empty. Drives the write and read pointers plus the qualified push/pop strobes into the memory. Publishes occupancy, threshold flags and sticky overflow/underflow errors to the flow-control logic.

Parameters:
MEM_SIZE, 8, number of FIFO entries; must equal 2**PTR
PTR, 3, pointer width in bits
CNT_W, 4, occupancy counter width (PTR+1), so it can represent MEM_SIZE

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low reset
push_req  input  1  producer write request
pop_req  input  1  consumer read request
af_thr  input  CNT_W  almost-full threshold
ae_thr  input  CNT_W  almost-empty threshold
wr_ptr  output  PTR  write pointer to memory
rd_ptr  output  PTR  read pointer to memory
push  output  1  qualified write strobe to memory
pop  output  1  qualified read strobe to memory
count  output  CNT_W  current occupancy, 0..MEM_SIZE
full  output  1  count == MEM_SIZE
empty  output  1  count == 0
almost_full  output  1  count >= af_thr
almost_empty  output  1  count <= ae_thr
overflow_err  output  1  sticky: push_req was seen while full
underflow_err  output  1  sticky: pop_req was seen while empty

Behaviour:
- Reset: synchronous and active-low. While reset==0 at posedge, wr_ptr, rd_ptr, count, overflow_err and underflow_err all become 0.
- Strobes while reset==0: push and pop are forced to 0 combinationally.
- Resulting flag values in reset: empty=1, full=0, almost_full=(0>=af_thr), almost_empty=1.
- Qualification is combinational: push = reset && push_req && !full; pop = reset && pop_req && !empty.
- Read latency: the memory reads combinationally on pop, so data for rd_ptr is valid in the same cycle pop is high.
- rd_ptr advances at the posedge that ends that cycle.
- Pointer update: on push, wr_ptr <= wr_ptr+1, wrapping from MEM_SIZE-1 to 0. On pop, rd_ptr <= rd_ptr+1, with the same wrap.
- Count update: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Simultaneous push_req and pop_req:
  - Neither full nor empty: both are granted; count is unchanged and both pointers advance.
  - Full: pop is granted; push is blocked; overflow_err is set; count goes to MEM_SIZE-1.
  - Empty: push is granted; pop is blocked; underflow_err is set; count goes to 1.
- Flags: full, empty, almost_full and almost_empty are combinational from the registered count and the threshold inputs. They never contradict count.
- Thresholds: af_thr and ae_thr are treated as quasi-static. A change takes effect on the flags in the same cycle.
- Error flags:
  - overflow_err is set at the posedge where push_req && full; underflow_err is set at the posedge where pop_req && empty.
  - Both hold until reset. Blocked requests never move pointers or count.
- Invariant: (wr_ptr - rd_ptr) mod MEM_SIZE == count mod MEM_SIZE at all times. full implies wr_ptr == rd_ptr.
- Reset mid-operation: contents are abandoned. Pointers and count go to 0 at that edge, and any request in that cycle is ignored.

Decomposition:
- Shared package: MEM_SIZE, PTR, CNT_W defaults; the rule CNT_W = PTR+1.
- One sub-module: fifo_ptr_cnt, a wrapping PTR-bit incrementer with enable and synchronous active-low clear. It is instantiated twice, once for wr_ptr and once for rd_ptr.
- The count and flag logic stay in fifo_ctrl.

Test Plan:
1. Hold reset=0 for 2 cycles with push_req=pop_req=1 -> push=pop=0, count=0, empty=1, full=0, both errors 0.
2. Issue 8 consecutive pushes from reset, then a 9th push_req -> count 1..8, wr_ptr wraps 7->0, full=1 after the 8th push; 9th push=0, overflow_err=1, wr_ptr stays 0.
3. From full, issue 8 pops, then a 9th pop_req -> rd_ptr 0..7->0, empty=1, 9th pop=0, underflow_err=1.
4. With count=3, hold push_req=pop_req=1 for 10 cycles -> count stays 3, both pointers advance 10 (mod 8), no errors.
5. With af_thr=6 and ae_thr=2, push from 0 to 7 -> almost_empty=1 for count<=2, almost_full=1 for count>=6, full only at count 8.
6. At count=5 with errors set, assert reset=0 for one cycle -> next cycle count=0, pointers 0, errors cleared.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing defaults and flag bundle for the FIFO pointer/flag controller.
// The occupancy counter is one bit wider than the pointers so it can reach MEM_SIZE.
package fifo_ctrl_pkg;

    function automatic int unsigned cnt_width(input int unsigned ptr_w);
        return ptr_w + 1;
    endfunction

    localparam int unsigned DefPtr     = 3;
    localparam int unsigned DefMemSize = 2 ** DefPtr;
    localparam int unsigned DefCntW    = cnt_width(DefPtr);

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/threshold inputs and pointer/strobe/flag outputs of the FIFO controller.
// The master side is the producer/consumer/flow-control environment; the slave is fifo_ctrl.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned PTR   = DefPtr,
    parameter int unsigned CNT_W = DefCntW
) ();

    logic             push_req;
    logic             pop_req;
    logic [CNT_W-1:0] af_thr;
    logic [CNT_W-1:0] ae_thr;
    logic [PTR-1:0]   wr_ptr;
    logic [PTR-1:0]   rd_ptr;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow_err;
    logic             underflow_err;

    modport master (
        output push_req, pop_req, af_thr, ae_thr,
        input  wr_ptr, rd_ptr, push, pop, count, full, empty,
        input  almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  push_req, pop_req, af_thr, ae_thr,
        output wr_ptr, rd_ptr, push, pop, count, full, empty,
        output almost_full, almost_empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/fifo_ptr_cnt.sv
// Wrapping W-bit pointer with advance enable and synchronous active-low clear.
module fifo_ptr_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    // Natural W-bit overflow gives the MEM_SIZE-1 -> 0 wrap since MEM_SIZE == 2**W.
    assign ptr_d = en_i ? ptr_q + W'(1) : ptr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer and flag controller: qualifies push/pop against full/empty, tracks
// occupancy, derives threshold flags and holds sticky overflow/underflow errors.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned PTR      = DefPtr,
    parameter int unsigned MEM_SIZE = 2 ** PTR,
    parameter int unsigned CNT_W    = cnt_width(PTR)
) (
    input logic        clk,
    input logic        reset,
    fifo_ctrl_if.slave bus
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push, pop;
    logic [PTR-1:0]   wr_ptr, rd_ptr;
    flags_t           flags;

    always_comb begin
        flags.full         = (count_q == CNT_W'(MEM_SIZE));
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= bus.af_thr);
        flags.almost_empty = (count_q <= bus.ae_thr);
    end

    // Strobes are gated by reset so a request in a reset cycle never reaches memory.
    assign push = reset && bus.push_req && !flags.full;
    assign pop  = reset && bus.pop_req && !flags.empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign ovf_d = ovf_q | (bus.push_req & flags.full);
    assign unf_d = unf_q | (bus.pop_req & flags.empty);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_ptr_cnt #(.W(PTR)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en_i  (push),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_cnt #(.W(PTR)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en_i  (pop),
        .ptr_o (rd_ptr)
    );

    assign bus.wr_ptr        = wr_ptr;
    assign bus.rd_ptr        = rd_ptr;
    assign bus.push          = push;
    assign bus.pop           = pop;
    assign bus.count         = count_q;
    assign bus.full          = flags.full;
    assign bus.empty         = flags.empty;
    assign bus.almost_full   = flags.almost_full;
    assign bus.almost_empty  = flags.almost_empty;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a token-queue model predicts every cycle's outputs,
// a negedge monitor pops predictions and compares them with the DUT.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int unsigned MemSize = DefMemSize;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.PTR(DefPtr), .CNT_W(DefCntW)) bus ();

    fifo_ctrl #(.PTR(DefPtr), .MEM_SIZE(DefMemSize), .CNT_W(DefCntW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          push;
        bit          pop;
        int unsigned wr;
        int unsigned rd;
        int unsigned cnt;
        bit          full;
        bit          empty;
        bit          af;
        bit          ae;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t        sb[$];
    // Model: each entry is the slot address it was written to, oldest first.
    int unsigned m_fifo[$];
    int unsigned m_wr;
    bit          m_ovf;
    bit          m_unf;
    int unsigned thr_af = 6;
    int unsigned thr_ae = 2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit pr, input bit qr);
        exp_t        e;
        int unsigned sz;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.push_req = pr;
        bus.pop_req  = qr;
        bus.af_thr   = DefCntW'(thr_af);
        bus.ae_thr   = DefCntW'(thr_ae);
        sz      = m_fifo.size();
        e.cnt   = sz;
        e.full  = (sz == MemSize);
        e.empty = (sz == 0);
        e.af    = (sz >= thr_af);
        e.ae    = (sz <= thr_ae);
        e.wr    = m_wr;
        // Empty means the pointers coincide; otherwise rd points at the oldest entry.
        e.rd    = (sz == 0) ? m_wr : m_fifo[0];
        e.push  = rst && pr && !e.full;
        e.pop   = rst && qr && !e.empty;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
        if (!rst) begin
            m_fifo.delete();
            m_wr  = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (pr && e.full)  m_ovf = 1;
            if (qr && e.empty) m_unf = 1;
            if (e.pop) void'(m_fifo.pop_front());
            if (e.push) begin
                m_fifo.push_back(m_wr);
                m_wr = (m_wr + 1) % MemSize;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("push",          bus.push,          e.push);
                check("pop",           bus.pop,           e.pop);
                check("wr_ptr",        bus.wr_ptr,        e.wr);
                check("rd_ptr",        bus.rd_ptr,        e.rd);
                check("count",         bus.count,         e.cnt);
                check("full",          bus.full,          e.full);
                check("empty",         bus.empty,         e.empty);
                check("almost_full",   bus.almost_full,   e.af);
                check("almost_empty",  bus.almost_empty,  e.ae);
                check("overflow_err",  bus.overflow_err,  e.ovf);
                check("underflow_err", bus.underflow_err, e.unf);
            end
        end
    end

    initial begin : stimulus
        int unsigned bias;
        bit          rst;
        reset        = 1'b0;
        bus.push_req = 1'b1;
        bus.pop_req  = 1'b1;
        bus.af_thr   = DefCntW'(thr_af);
        bus.ae_thr   = DefCntW'(thr_ae);
        m_wr = 0; m_ovf = 0; m_unf = 0;

        repeat (2) drive(0, 1, 1);               // reset with requests active
        for (int i = 0; i < 9; i++) drive(1, 1, 0);  // fill, wrap, then overflow
        for (int i = 0; i < 9; i++) drive(1, 0, 1);  // drain, wrap, then underflow
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 1); // steady count of 3
        drive(0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 0);  // threshold sweep 0..8
        drive(1, 1, 0);                              // overflow
        for (int i = 0; i < 8; i++) drive(1, 0, 1);
        drive(1, 0, 1);                              // underflow
        for (int i = 0; i < 5; i++) drive(1, 1, 0);  // count 5, both errors set
        drive(0, 1, 1);                              // mid-operation reset
        drive(1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            bias = ((i / 60) % 3 == 0) ? 80 : (((i / 60) % 3 == 1) ? 20 : 50);
            if ($urandom_range(0, 24) == 0) begin
                thr_af = $urandom_range(0, 9);
                thr_ae = $urandom_range(0, 9);
            end
            rst = ($urandom_range(0, 79) != 0);
            drive(rst, $urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias);
            if ($urandom_range(0, 3) == 0)
                drive(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
